cluster_frame_collector: RTL and testbench
==========================================

Name: cluster_frame_collector

Overview:
- Sits directly downstream of the 192-pad priority encoder in the cluster-building chain.
- Consumes one {vpf, cnt, adr} result per clock and gathers the found clusters belonging to one bunch-crossing frame into a fixed-size slot buffer.
- Publishes the buffer as a registered parallel word with cluster count, overflow flag and pass tag, ready for the cluster packer/formatter.

Parameters:
MXKEYBITS, 8, address width of the incoming cluster (matches encoder adr)
MXCNTB, 3, cluster size/count field width
MXCLUSTERS, 8, slots per frame
FRAME_LEN, 8, clock cycles per frame (timeout length)
MXNB, 4, width of nclusters_out; must hold MXCLUSTERS (clog2(MXCLUSTERS+1))

Ports:
clock  in  1  system clock, all logic rising-edge
reset_n  in  1  asynchronous, active-low reset
frame_in  in  1  high on cycle 0 of a new frame, aligned with encoder outputs
pass_in  in  3  pass/tag bits from encoder, sampled with frame_in
vpf_in  in  1  encoder valid-pattern flag
cnt_in  in  MXCNTB  encoder cluster count
adr_in  in  MXKEYBITS  encoder address (all-ones when vpf_in=0)
clusters_out  out  MXCLUSTERS*(MXCNTB+MXKEYBITS)  slot i = bits [i*W+W-1 : i*W], W=MXCNTB+MXKEYBITS, slot = {cnt, adr}
nclusters_out  out  MXNB  valid slots in published frame
overflow_out  out  1  frame had more than MXCLUSTERS valid inputs
tag_out  out  3  pass_in latched at the frame start
valid_out  out  1  one-cycle pulse when outputs update
busy_out  out  1  high while state = COLLECT

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Empty-slot pattern: cnt = 0, adr = all ones.
- Reset values:
  - clusters_out = all slots empty.
  - nclusters_out = 0, overflow_out = 0, tag_out = 0, valid_out = 0, busy_out = 0.
  - Internal buffer cleared; state = IDLE.
- States:
  - IDLE: no open frame. vpf_in is ignored unless frame_in = 1. frame_in = 1 -> COLLECT.
  - COLLECT: frame open; cycle counter fc counts sampled cycles 0..FRAME_LEN-1.
- Frame open (frame_in = 1 in either state):
  - Buffer cleared, fc = 0, tag latched from pass_in.
  - The input on that same cycle is treated as the first sample of the new frame.
- Sample rule in COLLECT:
  - vpf_in = 1 with wptr < MXCLUSTERS: slot[wptr] <= {cnt_in, adr_in}, wptr++.
  - vpf_in = 1 with wptr = MXCLUSTERS: data dropped, overflow flag set (sticky for the frame).
  - vpf_in = 0: no write.
- Frame close, on the first of:
  - (a) frame_in = 1 while in COLLECT (back-to-back frame);
  - (b) FRAME_LEN cycles sampled (fc = FRAME_LEN-1 this cycle, no frame_in on the next).
  - On close, the buffer, wptr, overflow and tag transfer to the output registers. valid_out pulses exactly one cycle, on the cycle after the last sampled cycle of the frame.
  - Case (a): the new frame opens in the same cycle (state stays COLLECT). Case (b): state -> IDLE.
- Latency: a cluster sampled on cycle k of a frame appears on the outputs FRAME_LEN-k cycles later for a timed-out frame. For a frame closed by frame_in, it appears on the cycle after frame_in.
- Outputs hold between publishes; valid_out = 0 otherwise.
- Ordering: slots are filled in arrival order; slot 0 = first valid cluster.
- Arithmetic: wptr saturates at MXCLUSTERS and never wraps. fc saturates and has no wrap.
- Reset mid-frame: the partial frame is discarded and no valid_out is issued.

Optional Feature:
CLUSTER_FRAME_COLLECTOR_DEDUP_EN
- Defined: a valid input whose {cnt, adr} equals the most recently written slot in the same frame is not written and does not advance wptr. It also does not count toward overflow. The comparison register is cleared at each frame open.
- Undefined: every valid input is written; no comparison logic is built.

Test Plan:
1. Reset, then frame_in with vpf_in = 1, cnt = 2, adr = 0x05 at cycle 0, vpf = 0 after -> after 8 cycles valid_out = 1 for one cycle; slot0 = {2, 0x05}, slots1-7 = {0, 0xFF}; nclusters = 1; overflow = 0.
2. Frame with 10 consecutive valid inputs, adr = 0..9 -> nclusters = 8, slots hold adr 0..7, overflow = 1.
3. frame_in on cycle 0 and again on cycle 3, pass_in = 3'b001 then 3'b010 -> first publish on cycle 4 with tag = 1 and the cycles 0-2 clusters. Cycle-3 data belongs to the second frame; its tag = 2.
4. vpf_in = 1 pulses while IDLE with no frame_in -> no valid_out; outputs unchanged.
5. reset_n asserted low at cycle 4 of a frame holding 3 clusters -> outputs return to reset values immediately; no valid_out after release.
6. With DEDUP_EN, inputs adr 0x10, 0x10, 0x11 (same cnt) -> nclusters = 2, slots = 0x10, 0x11. Without DEDUP_EN -> nclusters = 3.

Source files
------------

// File: rtl/cluster_frame_collector.sv
// cluster_frame_collector
//   Gathers the clusters found by the priority encoder during one bunch-crossing
//   frame into MXCLUSTERS slots and publishes them as one registered word with
//   cluster count, overflow flag and pass tag.
//   Optional build macro: CLUSTER_FRAME_COLLECTOR_DEDUP_EN suppresses a valid
//   input equal to the most recently written slot of the same frame.
//   FRAME_LEN must be at least 2.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no open frame; inputs ignored until frame_in
//   COLLECT | frame open; fc_q is the in-frame index of the current cycle
module cluster_frame_collector #(
    parameter int MXKEYBITS  = 8,
    parameter int MXCNTB     = 3,
    parameter int MXCLUSTERS = 8,
    parameter int FRAME_LEN  = 8,
    parameter int MXNB       = 4
) (
    input  logic                                          clock,
    input  logic                                          reset_n,
    input  logic                                          frame_in,
    input  logic [2:0]                                    pass_in,
    input  logic                                          vpf_in,
    input  logic [MXCNTB-1:0]                             cnt_in,
    input  logic [MXKEYBITS-1:0]                          adr_in,
    output logic [MXCLUSTERS*(MXCNTB+MXKEYBITS)-1:0]      clusters_out,
    output logic [MXNB-1:0]                               nclusters_out,
    output logic                                          overflow_out,
    output logic [2:0]                                    tag_out,
    output logic                                          valid_out,
    output logic                                          busy_out
);

    localparam int W   = MXCNTB + MXKEYBITS;
    localparam int FCW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
    localparam logic [W-1:0]    EMPTY     = {{MXCNTB{1'b0}}, {MXKEYBITS{1'b1}}};
    localparam logic [MXNB-1:0] WPTR_FULL = MXNB'(MXCLUSTERS);
    localparam logic [FCW-1:0]  FC_LAST   = FCW'(FRAME_LEN - 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t                           state_q, state_d;
    logic [FCW-1:0]                   fc_q, fc_d;
    logic [MXCLUSTERS-1:0][W-1:0]     buf_q, buf_d, base_buf;
    logic [MXNB-1:0]                  wptr_q, wptr_d, base_wptr;
    logic                             ovf_q, ovf_d, base_ovf;
    logic [2:0]                       tag_q, tag_d;

    logic [MXCLUSTERS-1:0][W-1:0]     obuf_q, pub_buf;
    logic [MXNB-1:0]                  on_q, pub_n;
    logic                             oovf_q, pub_ovf;
    logic [2:0]                       otag_q, pub_tag;
    logic                             valid_q;

    logic                             pub_en;
    logic                             pub_cur;
    logic                             sample_en;
    logic [W-1:0]                     word;
    logic                             dup;

`ifdef CLUSTER_FRAME_COLLECTOR_DEDUP_EN
    logic [W-1:0] last_q, last_d;
    logic         last_vld_q, last_vld_d;

    // Flag an input that repeats the last written slot; a frame open forgets it.
    always_comb begin
        dup = vpf_in && !frame_in && last_vld_q && ({cnt_in, adr_in} == last_q);
    end

    // Track the most recently written slot of the current frame.
    always_comb begin
        last_d     = last_q;
        last_vld_d = frame_in ? 1'b0 : last_vld_q;
        if (wptr_d != base_wptr) begin
            last_d     = word;
            last_vld_d = 1'b1;
        end
    end

    // Dedup comparison register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q     <= EMPTY;
            last_vld_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // Next state, frame open/close and slot write; the frame-open cycle is also
    // the first sample of the new frame, so sampling is applied on top of the
    // (possibly cleared) base buffer.
    always_comb begin
        state_d   = state_q;
        fc_d      = fc_q;
        tag_d     = tag_q;
        base_buf  = buf_q;
        base_wptr = wptr_q;
        base_ovf  = ovf_q;
        pub_en    = 1'b0;
        pub_cur   = 1'b0;

        if (frame_in) begin
            pub_en    = (state_q == COLLECT);
            base_buf  = {MXCLUSTERS{EMPTY}};
            base_wptr = '0;
            base_ovf  = 1'b0;
            tag_d     = pass_in;
            fc_d      = FCW'(1);
            state_d   = COLLECT;
        end else if (state_q == COLLECT) begin
            if (fc_q == FC_LAST) begin
                // Last sampled cycle: publish including this cycle's sample.
                state_d = IDLE;
                pub_en  = 1'b1;
                pub_cur = 1'b1;
            end else begin
                fc_d = fc_q + FCW'(1);
            end
        end

        sample_en = frame_in || (state_q == COLLECT);
        word      = {cnt_in, adr_in};
        buf_d     = base_buf;
        wptr_d    = base_wptr;
        ovf_d     = base_ovf;

        if (sample_en && vpf_in && !dup) begin
            if (base_wptr < WPTR_FULL) begin
                for (int i = 0; i < MXCLUSTERS; i++) begin
                    if (base_wptr == MXNB'(i)) buf_d[i] = word;
                end
                wptr_d = base_wptr + MXNB'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end

        // A back-to-back close publishes the old frame, a timeout the updated one.
        if (pub_cur) begin
            pub_buf = buf_d;
            pub_n   = wptr_d;
            pub_ovf = ovf_d;
        end else begin
            pub_buf = buf_q;
            pub_n   = wptr_q;
            pub_ovf = ovf_q;
        end
        pub_tag = tag_q;
    end

    // Frame state and collection buffer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            fc_q    <= '0;
            buf_q   <= {MXCLUSTERS{EMPTY}};
            wptr_q  <= '0;
            ovf_q   <= 1'b0;
            tag_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
            buf_q   <= buf_d;
            wptr_q  <= wptr_d;
            ovf_q   <= ovf_d;
            tag_q   <= tag_d;
        end
    end

    // Published frame registers; held between publishes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            obuf_q  <= {MXCLUSTERS{EMPTY}};
            on_q    <= '0;
            oovf_q  <= 1'b0;
            otag_q  <= 3'b000;
            valid_q <= 1'b0;
        end else begin
            valid_q <= pub_en;
            if (pub_en) begin
                obuf_q <= pub_buf;
                on_q   <= pub_n;
                oovf_q <= pub_ovf;
                otag_q <= pub_tag;
            end
        end
    end

    assign clusters_out  = obuf_q;
    assign nclusters_out = on_q;
    assign overflow_out  = oovf_q;
    assign tag_out       = otag_q;
    assign valid_out     = valid_q;
    assign busy_out      = (state_q == COLLECT);

endmodule

// File: tb/tb_cluster_frame_collector.sv
// Bench for cluster_frame_collector: directed scenarios with literal
// expectations plus randomized frames, all checked every cycle against a
// queue-based frame model.  FRAME_LEN is raised to 12 so that a single frame
// can carry more than MXCLUSTERS valid inputs.
module tb_cluster_frame_collector;

    localparam int KB  = 8;
    localparam int CB  = 3;
    localparam int NCL = 8;
    localparam int FL  = 12;
    localparam int NB  = 4;
    localparam int W   = CB + KB;
    localparam logic [W-1:0] EMPTY = {3'b000, 8'hFF};

    logic               clock;
    logic               reset_n;
    logic               frame_in;
    logic [2:0]         pass_in;
    logic               vpf_in;
    logic [CB-1:0]      cnt_in;
    logic [KB-1:0]      adr_in;
    logic [NCL*W-1:0]   clusters_out;
    logic [NB-1:0]      nclusters_out;
    logic               overflow_out;
    logic [2:0]         tag_out;
    logic               valid_out;
    logic               busy_out;

    cluster_frame_collector #(
        .MXKEYBITS(KB), .MXCNTB(CB), .MXCLUSTERS(NCL), .FRAME_LEN(FL), .MXNB(NB)
    ) dut (
        .clock(clock), .reset_n(reset_n), .frame_in(frame_in), .pass_in(pass_in),
        .vpf_in(vpf_in), .cnt_in(cnt_in), .adr_in(adr_in),
        .clusters_out(clusters_out), .nclusters_out(nclusters_out),
        .overflow_out(overflow_out), .tag_out(tag_out), .valid_out(valid_out),
        .busy_out(busy_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Frame model: accepted clusters of the open frame kept in a queue.
    bit               m_open;
    int               m_samples;
    logic [W-1:0]     m_items[$];
    bit               m_ovf;
    logic [2:0]       m_tag;
    logic [W-1:0]     m_last;
    bit               m_last_vld;

    logic [NCL*W-1:0] e_clusters;
    logic [NB-1:0]    e_n;
    logic             e_ovf;
    logic [2:0]       e_tag;
    logic             e_valid;
    logic             e_busy;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_open = 0; m_samples = 0; m_items.delete(); m_ovf = 0; m_tag = 3'b000;
        m_last = EMPTY; m_last_vld = 0;
        for (int i = 0; i < NCL; i++) e_clusters[i*W +: W] = EMPTY;
        e_n = '0; e_ovf = 0; e_tag = 3'b000; e_valid = 0; e_busy = 0;
    endfunction

    function automatic void model_publish();
        for (int i = 0; i < NCL; i++)
            e_clusters[i*W +: W] = (i < m_items.size()) ? m_items[i] : EMPTY;
        e_n     = NB'(m_items.size());
        e_ovf   = m_ovf;
        e_tag   = m_tag;
        e_valid = 1;
    endfunction

    function automatic void model_accept(input logic v, input logic [W-1:0] wd);
        if (!v) return;
`ifdef CLUSTER_FRAME_COLLECTOR_DEDUP_EN
        if (m_last_vld && wd == m_last) return;
`endif
        if (m_items.size() < NCL) begin
            m_items.push_back(wd);
            m_last = wd;
            m_last_vld = 1;
        end else begin
            m_ovf = 1;
        end
    endfunction

    function automatic void model_step(input logic f, input logic [2:0] p, input logic v,
                                       input logic [W-1:0] wd);
        e_valid = 0;
        if (f) begin
            if (m_open) model_publish();
            m_items.delete(); m_ovf = 0; m_tag = p; m_last_vld = 0;
            m_open = 1;
            model_accept(v, wd);
            m_samples = 1;
        end else if (m_open) begin
            model_accept(v, wd);
            m_samples++;
            if (m_samples == FL) begin
                model_publish();
                m_open = 0;
            end
        end
        e_busy = m_open;
    endfunction

    task automatic step(input logic f, input logic [2:0] p, input logic v,
                        input logic [CB-1:0] c, input logic [KB-1:0] a);
        logic [KB-1:0] ae;
        ae = v ? a : 8'hFF;
        frame_in = f; pass_in = p; vpf_in = v; cnt_in = c; adr_in = ae;
        @(posedge clock);
        model_step(f, p, v, {c, ae});
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'b000, 1'b0, 3'd0, 8'h00);
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_n",     128'(nclusters_out), 128'(0));
        chk("rst_busy",  128'(busy_out),      128'(0));
        chk("rst_valid", 128'(valid_out),     128'(0));
        chk("rst_clu",   128'(clusters_out),  128'(e_clusters));
        @(negedge clock);
        @(negedge clock);
        #2;
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // Compare every output against the model on every cycle.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("cmp_clusters", 128'(clusters_out),  128'(e_clusters));
            chk("cmp_n",        128'(nclusters_out), 128'(e_n));
            chk("cmp_ovf",      128'(overflow_out),  128'(e_ovf));
            chk("cmp_tag",      128'(tag_out),       128'(e_tag));
            chk("cmp_valid",    128'(valid_out),     128'(e_valid));
            chk("cmp_busy",     128'(busy_out),      128'(e_busy));
        end
    end

    initial begin
        logic [NB-1:0] n_exp6;
        logic [W-1:0]  s1_exp6;
        frame_in = 0; pass_in = 0; vpf_in = 0; cnt_in = 0; adr_in = 8'hFF;
        reset_n = 1'b1;
        model_reset();
        @(negedge clock);
        do_reset();
        chk_en = 1;

        // 1: single cluster, timeout publish
        step(1'b1, 3'b101, 1'b1, 3'd2, 8'h05);
        idle(FL - 2);
        chk("t1_novalid_early", 128'(valid_out), 128'(0));
        idle(1);
        chk("t1_valid", 128'(valid_out),             128'(1));
        chk("t1_slot0", 128'(clusters_out[10:0]),    128'(11'h205));
        chk("t1_slot7", 128'(clusters_out[87:77]),   128'(11'h0FF));
        chk("t1_n",     128'(nclusters_out),         128'(1));
        chk("t1_ovf",   128'(overflow_out),          128'(0));
        chk("t1_tag",   128'(tag_out),               128'(5));
        idle(1);
        chk("t1_pulse", 128'(valid_out), 128'(0));

        // 2: ten valid inputs overflow eight slots
        step(1'b1, 3'b011, 1'b1, 3'd1, 8'h00);
        for (int i = 1; i < 10; i++) step(1'b0, 3'b000, 1'b1, 3'd1, 8'(i));
        idle(FL - 10);
        chk("t2_valid", 128'(valid_out),           128'(1));
        chk("t2_n",     128'(nclusters_out),       128'(8));
        chk("t2_ovf",   128'(overflow_out),        128'(1));
        chk("t2_slot0", 128'(clusters_out[10:0]),  128'(11'h100));
        chk("t2_slot7", 128'(clusters_out[87:77]), 128'(11'h107));

        // 3: back-to-back frames
        step(1'b1, 3'b001, 1'b1, 3'd3, 8'h20);
        step(1'b0, 3'b000, 1'b1, 3'd3, 8'h21);
        step(1'b0, 3'b000, 1'b1, 3'd3, 8'h22);
        step(1'b1, 3'b010, 1'b1, 3'd4, 8'h30);
        chk("t3_valid1", 128'(valid_out),           128'(1));
        chk("t3_tag1",   128'(tag_out),             128'(1));
        chk("t3_n1",     128'(nclusters_out),       128'(3));
        chk("t3_slot2",  128'(clusters_out[32:22]), 128'(11'h322));
        chk("t3_busy",   128'(busy_out),            128'(1));
        idle(FL - 1);
        chk("t3_valid2", 128'(valid_out),          128'(1));
        chk("t3_tag2",   128'(tag_out),            128'(2));
        chk("t3_n2",     128'(nclusters_out),      128'(1));
        chk("t3_slot0b", 128'(clusters_out[10:0]), 128'(11'h430));

        // 4: valid inputs while idle are ignored
        for (int i = 0; i < 5; i++) step(1'b0, 3'b111, 1'b1, 3'd7, 8'(8'h50 + i));
        chk("t4_valid", 128'(valid_out),     128'(0));
        chk("t4_n",     128'(nclusters_out), 128'(1));
        chk("t4_busy",  128'(busy_out),      128'(0));

        // 5: reset in the middle of a frame
        step(1'b1, 3'b110, 1'b1, 3'd1, 8'h40);
        step(1'b0, 3'b000, 1'b1, 3'd1, 8'h41);
        step(1'b0, 3'b000, 1'b1, 3'd1, 8'h42);
        step(1'b0, 3'b000, 1'b0, 3'd0, 8'h00);
        do_reset();
        idle(FL + 2);
        chk("t5_valid", 128'(valid_out), 128'(0));
        chk("t5_n",     128'(nclusters_out), 128'(0));

        // 6: repeated cluster
        step(1'b1, 3'b100, 1'b1, 3'd1, 8'h10);
        step(1'b0, 3'b000, 1'b1, 3'd1, 8'h10);
        step(1'b0, 3'b000, 1'b1, 3'd1, 8'h11);
        idle(FL - 3);
`ifdef CLUSTER_FRAME_COLLECTOR_DEDUP_EN
        n_exp6 = 4'd2; s1_exp6 = 11'h111;
`else
        n_exp6 = 4'd3; s1_exp6 = 11'h110;
`endif
        chk("t6_valid", 128'(valid_out),           128'(1));
        chk("t6_n",     128'(nclusters_out),       128'(n_exp6));
        chk("t6_slot1", 128'(clusters_out[21:11]), 128'(s1_exp6));

        // Randomized frames against the model
        for (int seg = 0; seg < 3; seg++) begin
            for (int i = 0; i < 800; i++) begin
                logic f, v;
                logic [2:0] p, c;
                logic [7:0] a;
                f = ($urandom_range(0, 13) == 0);
                v = (seg == 1) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 9) < 6);
                p = 3'($urandom_range(0, 7));
                c = (seg == 2) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
                a = (seg == 2) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(0, 254));
                step(f, p, v, c, a);
                if ($urandom_range(0, 499) == 0) do_reset();
            end
        end
        idle(FL + 2);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
